// File: rtl/code_lock.sv
// Symbol-stream combination lock: collects symbols in stride order, checks the newest DEPTH on commit.
// Optional failure lockout enabled by defining CODE_LOCK_LOCKOUT_EN.
module code_lock #(
    parameter int                          SYM_W       = 7,
    parameter int                          DEPTH       = 8,
    parameter int                          STRIDE      = 5,
    parameter int                          ROT         = 0,
    parameter logic [DEPTH*SYM_W-1:0]      SECRET      = '0,
    parameter int                          MAX_FAIL    = 3,
    parameter int                          LOCKOUT_CYC = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [SYM_W-1:0]               in_data,
    output logic                           in_ready,
    input  logic                           commit,
    input  logic                           relock,
    output logic                           open_safe,
    output logic                           locked_out,
    output logic [$clog2(MAX_FAIL+1)-1:0]  fail_cnt
);

    localparam int CODE_W = DEPTH * SYM_W;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int FC_W   = $clog2(MAX_FAIL + 1);
    localparam int ROT_N  = ROT % CODE_W;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_CHECK   = 2'd1,
        S_OPEN    = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [SYM_W-1:0]    r_mem [DEPTH];
    logic [IDX_W-1:0]    r_idx;
    logic [CNT_W-1:0]    r_count;
    logic [FC_W-1:0]     r_fail_cnt;

    logic                w_accept;
    logic                w_full;
    logic                w_match;
    logic [FC_W-1:0]     w_fail_inc;
    logic                w_lock_hit;
    logic                w_lock_done;
    logic [CODE_W-1:0]   w_packed;
    logic [CODE_W-1:0]   w_rot;

    assign w_accept   = in_valid && (r_state == S_COLLECT);
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_match    = w_full && (w_rot == SECRET);
    assign w_fail_inc = (r_fail_cnt == FC_W'(MAX_FAIL)) ? r_fail_cnt : r_fail_cnt + FC_W'(1);

    // Slot i occupies bits [i*SYM_W +: SYM_W] of the packed code.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pack
            assign w_packed[gi*SYM_W +: SYM_W] = r_mem[gi];
        end
        if (ROT_N == 0) begin : g_rot_none
            assign w_rot = w_packed;
        end else begin : g_rot_left
            assign w_rot = (w_packed << ROT_N) | (w_packed >> (CODE_W - ROT_N));
        end
    endgenerate

`ifdef CODE_LOCK_LOCKOUT_EN
    localparam int TMR_W = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

    logic [TMR_W-1:0] r_tmr;

    assign w_lock_hit  = (w_fail_inc == FC_W'(MAX_FAIL));
    assign w_lock_done = (r_tmr == TMR_W'(LOCKOUT_CYC - 1));

    // Timer is zero on LOCKOUT entry, so the state lasts exactly LOCKOUT_CYC cycles.
    always_ff @(posedge clk) begin
        if (rst || r_state != S_LOCKOUT) begin
            r_tmr <= '0;
        end else begin
            r_tmr <= r_tmr + TMR_W'(1);
        end
    end
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (LOCKOUT_CYC > 0);
    assign w_lock_hit   = 1'b0;
    assign w_lock_done  = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_COLLECT: if (commit) w_state_next = S_CHECK;
            S_CHECK: begin
                if (w_match)         w_state_next = S_OPEN;
                else if (w_lock_hit) w_state_next = S_LOCKOUT;
                else                 w_state_next = S_COLLECT;
            end
            S_OPEN:    if (relock) w_state_next = S_COLLECT;
            S_LOCKOUT: if (w_lock_done) w_state_next = S_COLLECT;
            default:   w_state_next = S_COLLECT;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_COLLECT);
        open_safe = (r_state == S_OPEN);
`ifdef CODE_LOCK_LOCKOUT_EN
        locked_out = (r_state == S_LOCKOUT);
`else
        locked_out = 1'b0;
`endif
        fail_cnt  = r_fail_cnt;
    end

    // Symbol store carries no reset so it maps onto plain storage.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_idx] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_count    <= '0;
            r_fail_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_idx <= r_idx + IDX_W'(STRIDE % DEPTH);
                if (!w_full) r_count <= r_count + CNT_W'(1);
            end
            if (r_state == S_CHECK) begin
                if (w_match) begin
                    r_fail_cnt <= '0;
                end else begin
                    r_fail_cnt <= w_fail_inc;
                    r_idx      <= '0;
                    r_count    <= '0;
                end
            end
            if (r_state == S_OPEN && relock) begin
                r_idx   <= '0;
                r_count <= '0;
            end
            if (r_state == S_LOCKOUT && w_lock_done) begin
                r_fail_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/code_lock.md
CODE_LOCK -- requirements
Module: code_lock

Interface
REQ-001 SHALL have parameter SYM_W, default 7, symbol width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, symbols per code; power of two, 2..64.
REQ-003 SHALL have parameter STRIDE, default 5, write-index increment; odd, so it visits all slots.
REQ-004 SHALL have parameter ROT, default 0, left-rotate amount applied to the packed code before compare.
REQ-005 SHALL have parameter SECRET, default 0, width DEPTH*SYM_W, expected rotated code.
REQ-006 SHALL have parameters MAX_FAIL (default 3) and LOCKOUT_CYC (default 16).
REQ-007 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port in_valid, input, 1, in_data carries a symbol.
REQ-010 SHALL have port in_data, input, SYM_W, symbol value.
REQ-011 SHALL have port in_ready, output, 1, symbol accepted when in_valid&&in_ready.
REQ-012 SHALL have port commit, input, 1, request evaluation of the collected code.
REQ-013 SHALL have port relock, input, 1, close an open safe.
REQ-014 SHALL have port open_safe, output, 1, code matched; held until relock.
REQ-015 SHALL have port locked_out, output, 1, lockout penalty active.
REQ-016 SHALL have port fail_cnt, output, clog2(MAX_FAIL+1), consecutive failures, saturating.

Function
REQ-017 SHALL implement states COLLECT, CHECK, OPEN, LOCKOUT; in_ready=1 only in COLLECT.
REQ-018 SHALL, on accept, write in_data to mem[idx], set idx=(idx+STRIDE) mod DEPTH, set count=min(count+1,DEPTH).
REQ-019 SHALL, when count==DEPTH, overwrite slots cyclically in stride order; the newest DEPTH symbols always form the code.
REQ-020 SHALL form packed={mem[DEPTH-1],...,mem[0]}; match when rotl(packed,ROT)==SECRET.
REQ-021 SHALL, on commit in COLLECT, go to CHECK next cycle; a symbol accepted in that same cycle is included.
REQ-022 SHALL, in CHECK (exactly 1 cycle), compare only when count==DEPTH; count<DEPTH is a failure.
REQ-023 SHALL, on match, go to OPEN, assert open_safe the next cycle, and clear fail_cnt.
REQ-024 SHALL, on failure, increment fail_cnt (saturating), clear idx/count, and return to COLLECT.
REQ-025 SHALL, on failure that brings fail_cnt to MAX_FAIL, go to LOCKOUT instead of COLLECT.
REQ-026 SHALL, in LOCKOUT, hold locked_out=1 for exactly LOCKOUT_CYC cycles; then clear fail_cnt and go to COLLECT.
REQ-027 SHALL ignore commit outside COLLECT, and ignore relock outside OPEN.
REQ-028 SHALL, on relock in OPEN, drop open_safe next cycle, clear idx/count, and go to COLLECT.
REQ-029 SHALL never assert open_safe and locked_out together.

Reset
REQ-030 SHALL, on rst, enter COLLECT with idx=0, count=0, fail_cnt=0, lockout timer=0, in_ready=1, open_safe=0, locked_out=0.
REQ-031 SHALL let rst override any state, including OPEN and mid-LOCKOUT; mem contents need not reset.

Configuration
REQ-032 SHALL, with CODE_LOCK_LOCKOUT_EN defined, implement LOCKOUT as in REQ-025/026.
REQ-033 SHALL, without CODE_LOCK_LOCKOUT_EN: omit LOCKOUT; every failure returns to COLLECT; locked_out tied 0; fail_cnt still counts and saturates.

Verification
REQ-034 SHALL cover: defaults with SECRET={7'h07,...,7'h00} (mem[i]=i); send 0,5,2,7,4,1,6,3 then commit -> open_safe=1 two cycles after commit; relock -> open_safe=0 next cycle.
REQ-035 SHALL cover: 5 symbols then commit -> fail_cnt=1, open_safe stays 0, in_ready=1 after the CHECK cycle.
REQ-036 SHALL cover: 3 wrong full codes (LOCKOUT_EN) -> locked_out=1 for exactly 16 cycles with in_ready=0, then fail_cnt=0.
REQ-037 SHALL cover: 11 symbols with the last 8 correct, then commit -> open_safe=1 (wrap-around overwrite).
REQ-038 SHALL cover: last symbol with in_valid and commit in the same cycle -> symbol included, match.
REQ-039 SHALL cover: rst asserted mid-LOCKOUT -> next cycle locked_out=0, fail_cnt=0, in_ready=1.
